// File: rtl/reggp_pkg.sv
// Shared constants and types for the general-purpose register file context logic.
package reggp_pkg;

  localparam int unsigned REGGP_DW    = 24;
  localparam int unsigned REGGP_AW    = 4;
  localparam int unsigned REGGP_NREGS = 2 ** REGGP_AW;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } state_t;

  localparam logic OP_SAVE    = 1'b0;
  localparam logic OP_RESTORE = 1'b1;

endpackage

// File: rtl/reggp_port_mux.sv
// Selects between the core and an internal sequencer for register file read port 1 and
// the write port. Read and write sides are selected independently.
module reggp_port_mux
  import reggp_pkg::*;
#(
  parameter int unsigned DW = REGGP_DW,
  parameter int unsigned AW = REGGP_AW
) (
  input  logic          seq_rd,
  input  logic          seq_wr,
  input  logic [AW-1:0] core_raddr1,
  input  logic [AW-1:0] core_waddr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  input  logic [AW-1:0] seq_raddr1,
  input  logic [AW-1:0] seq_waddr,
  input  logic [DW-1:0] seq_wdata,
  input  logic          seq_we,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we
);

  // Port select; the core keeps a side whenever the sequencer does not claim it.
  always_comb begin
    rf_raddr1 = seq_rd ? seq_raddr1 : core_raddr1;
    rf_waddr  = seq_wr ? seq_waddr  : core_waddr;
    rf_wdata  = seq_wr ? seq_wdata  : core_wdata;
    rf_we     = seq_wr ? seq_we     : core_we;
  end

endmodule

// File: rtl/reggp_ctx_seq.sv
// Context save/restore sequencer: streams a wrapping window of registers out of the
// register file (save) or into it (restore), stalling the core while it owns the ports.
module reggp_ctx_seq
  import reggp_pkg::*;
#(
  parameter int unsigned DW = REGGP_DW,
  parameter int unsigned AW = REGGP_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len,
  input  logic [AW-1:0] core_raddr1,
  input  logic [AW-1:0] core_waddr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  output logic          core_stall,
  output logic [AW-1:0] rf_raddr1,
  input  logic [DW-1:0] rf_rdata1,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  output logic          so_valid,
  input  logic          so_ready,
  output logic [DW-1:0] so_data,
  output logic          so_last,
  input  logic          si_valid,
  output logic          si_ready,
  input  logic [DW-1:0] si_data,
  output logic          done
);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] remain;
  logic          cmd_fire;
  logic          word_fire;

  // Handshake and stream decode from the registered state.
  always_comb begin
    cmd_ready  = (state == IDLE) && !core_we;
    cmd_fire   = cmd_valid && cmd_ready;
    core_stall = (state != IDLE);
    so_valid   = (state == SAVE);
    si_ready   = (state == RESTORE);
    so_last    = (state == SAVE) && (remain == '0);
    so_data    = (state == SAVE) ? rf_rdata1 : '0;
    word_fire  = (so_valid && so_ready) || (si_valid && si_ready);
  end

  // Read side is claimed only for SAVE; the write side for any busy state so a stray
  // core_we cannot corrupt the window (seq_we is zero during SAVE).
  reggp_port_mux #(
    .DW(DW),
    .AW(AW)
  ) u_port_mux (
    .seq_rd      (state == SAVE),
    .seq_wr      (state != IDLE),
    .core_raddr1 (core_raddr1),
    .core_waddr  (core_waddr),
    .core_wdata  (core_wdata),
    .core_we     (core_we),
    .seq_raddr1  (ptr),
    .seq_waddr   (ptr),
    .seq_wdata   (si_data),
    .seq_we      ((state == RESTORE) && si_valid),
    .rf_raddr1   (rf_raddr1),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we)
  );

  // FSM with window pointer, remaining count and the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      remain <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            ptr    <= cmd_base;
            remain <= cmd_len;
            state  <= (cmd_op == OP_RESTORE) ? RESTORE : SAVE;
          end
        end
        SAVE, RESTORE: begin
          if (word_fire) begin
            // Pointer wraps naturally at 2**AW.
            ptr    <= ptr + AW'(1);
            remain <= remain - AW'(1);
            if (remain == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reggp_ctx_seq.sv
// Self-checking bench for reggp_ctx_seq with a behavioural register file and window model.
module tb_reggp_ctx_seq;

  localparam int DW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_base, cmd_len;
  logic [AW-1:0] core_raddr1, core_waddr;
  logic [DW-1:0] core_wdata;
  logic          core_we, core_stall;
  logic [AW-1:0] rf_raddr1, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_wdata;
  logic          rf_we;
  logic          so_valid, so_ready, so_last;
  logic [DW-1:0] so_data;
  logic          si_valid, si_ready;
  logic [DW-1:0] si_data;
  logic          done;

  int n_checks = 0;
  int n_err    = 0;

  // Register file storage driven by the DUT, combinational read.
  logic [DW-1:0] mem [16];
  // Expected register contents, updated from the window rules.
  logic [DW-1:0] model [16];
  // Data words for the next restore.
  logic [DW-1:0] rdat [16];

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = mem[rf_raddr1];

  reggp_ctx_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .core_raddr1 (core_raddr1),
    .core_waddr  (core_waddr),
    .core_wdata  (core_wdata),
    .core_we     (core_we),
    .core_stall  (core_stall),
    .rf_raddr1   (rf_raddr1),
    .rf_rdata1   (rf_rdata1),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we),
    .so_valid    (so_valid),
    .so_ready    (so_ready),
    .so_data     (so_data),
    .so_last     (so_last),
    .si_valid    (si_valid),
    .si_ready    (si_ready),
    .si_data     (si_data),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < 16; r++) chk($sformatf("%s_reg%0d", tag, r), mem[r], model[r]);
  endtask

  // Accept a command: cmd_ready high in the offer cycle, stall from the next cycle.
  task automatic issue(input logic op, input logic [AW-1:0] base, input logic [AW-1:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_len   = len;
    core_we   = 1'b0;
    #2;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("stall_idle", core_stall, 0);
    step();
    cmd_valid = 1'b0;
    chk("stall_after_accept", core_stall, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  // Stream one window. mode: 0 always ready/valid, 1 pattern 1,0,0, 2 random.
  // stop >= 0 abandons the window after that many words (for reset testing).
  task automatic run_stream(input logic op, input logic [AW-1:0] base,
                            input logic [AW-1:0] len, input int mode, input int stop);
    int   idx = 0;
    int   cyc = 0;
    logic en;
    logic [AW-1:0] a;
    while (idx <= int'(len) && cyc < 300 && idx != stop) begin
      en = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      a  = AW'((int'(base) + idx) % 16);
      core_raddr1 = AW'($urandom);
      if (op == 1'b0) so_ready = en;
      else begin
        si_valid = en;
        si_data  = rdat[idx];
      end
      #2;
      chk("stall_busy", core_stall, 1);
      chk("done_busy", done, 0);
      if (op == 1'b0) begin
        chk("so_valid", so_valid, 1);
        chk($sformatf("so_data_w%0d", idx), so_data, model[a]);
        chk("so_last", so_last, (idx == int'(len)) ? 1 : 0);
        chk("rf_we_save", rf_we, 0);
        chk("si_ready_save", si_ready, 0);
      end else begin
        chk("si_ready", si_ready, 1);
        chk("rf_we_restore", rf_we, en);
        chk("rf_waddr", rf_waddr, a);
        chk("rf_wdata", rf_wdata, rdat[idx]);
        chk("raddr_pass_restore", rf_raddr1, core_raddr1);
        chk("so_valid_restore", so_valid, 0);
      end
      step();
      if (en) begin
        if (op == 1'b1) model[a] = rdat[idx];
        idx++;
      end
      cyc++;
    end
    so_ready = 1'b0;
    si_valid = 1'b0;
    if (idx != stop) begin
      chk("window_complete", idx, int'(len) + 1);
      chk("done_pulse", done, 1);
      chk("stall_released", core_stall, 0);
      step();
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    logic          op;
    logic [AW-1:0] b, l;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    core_raddr1 = '0; core_waddr = '0; core_wdata = '0; core_we = 1'b0;
    so_ready = 1'b0; si_valid = 1'b0; si_data = '0;
    #12;
    chk("rst_stall", core_stall, 0);
    chk("rst_so_valid", so_valid, 0);
    chk("rst_si_ready", si_ready, 0);
    chk("rst_so_last", so_last, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_we", rf_we, 0);
    rst_n = 1'b1;
    step();

    // Fill the register file through the idle pass-through path.
    for (int r = 0; r < 16; r++) begin
      v = DW'($urandom);
      core_we = 1'b1; core_waddr = AW'(r); core_wdata = v; core_raddr1 = AW'(15 - r);
      #2;
      chk("pass_we", rf_we, 1);
      chk("pass_waddr", rf_waddr, r);
      chk("pass_wdata", rf_wdata, v);
      chk("pass_raddr", rf_raddr1, 15 - r);
      chk("cmd_ready_core_we", cmd_ready, 0);
      step();
      model[r] = v;
    end
    core_we = 1'b0;
    check_mem("init");

    // Full restore then full save.
    for (int i = 0; i < 16; i++) rdat[i] = DW'(32'h100000 + i);
    issue(1'b1, 4'd0, 4'd15);
    run_stream(1'b1, 4'd0, 4'd15, 2, -1);
    check_mem("full_restore");
    issue(1'b0, 4'd0, 4'd15);
    run_stream(1'b0, 4'd0, 4'd15, 0, -1);

    // Wrap-around restore.
    for (int i = 0; i < 4; i++) rdat[i] = DW'($urandom);
    issue(1'b1, 4'd14, 4'd3);
    run_stream(1'b1, 4'd14, 4'd3, 0, -1);
    check_mem("wrap");

    // Backpressured save across the wrap.
    issue(1'b0, 4'd14, 4'd3);
    run_stream(1'b0, 4'd14, 4'd3, 1, -1);

    // Collision: a core write blocks the command for one cycle and lands.
    v = DW'($urandom);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 4'd4; cmd_len = 4'd2;
    core_we = 1'b1; core_waddr = 4'd5; core_wdata = v;
    #2;
    chk("coll_cmd_ready", cmd_ready, 0);
    chk("coll_rf_we", rf_we, 1);
    chk("coll_waddr", rf_waddr, 5);
    step();
    model[5] = v;
    core_we = 1'b0;
    chk("coll_stall_pending", core_stall, 0);
    #1;
    chk("coll_cmd_ready2", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("coll_stall", core_stall, 1);
    run_stream(1'b0, 4'd4, 4'd2, 0, -1);

    // Single-word save: done two cycles after accept.
    issue(1'b0, 4'd9, 4'd0);
    run_stream(1'b0, 4'd9, 4'd0, 0, -1);

    // Reset in the middle of a restore.
    for (int i = 0; i < 8; i++) rdat[i] = DW'($urandom);
    issue(1'b1, 4'd6, 4'd7);
    run_stream(1'b1, 4'd6, 4'd7, 0, 2);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_stall", core_stall, 0);
    chk("mid_rst_si_ready", si_ready, 0);
    chk("mid_rst_so_valid", so_valid, 0);
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_done", done, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_stall", core_stall, 0);
    check_mem("mid_rst");

    // Random commands with random flow control.
    for (int k = 0; k < 8; k++) begin
      op = 1'($urandom);
      b  = AW'($urandom);
      l  = AW'($urandom);
      for (int i = 0; i < 16; i++) rdat[i] = DW'($urandom);
      issue(op, b, l);
      run_stream(op, b, l, 2, -1);
    end
    check_mem("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
